// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives a synchronous-read instruction memory and
// delivers {pc, ins} pairs over valid/ready. Optional macro: FETCH_HALT_ON_ZERO_EN.
module fetch_unit #(
    parameter int PC_WIDTH   = 20,
    parameter int INS_WIDTH  = 20,
    parameter int IMEM_DEPTH = 20,
    parameter int RESET_PC   = 0,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PC_WIDTH-1:0]  imem_pc,
    input  logic [INS_WIDTH-1:0] imem_ins,
    input  logic                 redirect_valid,
    input  logic [PC_WIDTH-1:0]  redirect_pc,
    output logic                 if_valid,
    input  logic                 if_ready,
    output logic [INS_WIDTH-1:0] if_ins,
    output logic [PC_WIDTH-1:0]  if_pc,
    output logic                 halted
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int IW = $clog2(BUF_DEPTH);

    // FETCH: issuing; WAIT: out of buffer credit; HALT: stopped on a zero word.
    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_HALT
    } fetch_state_e;

    fetch_state_e state_q;

    logic [PC_WIDTH-1:0]  pc_q;
    logic [PC_WIDTH-1:0]  inflight_pc_q;
    logic                 inflight_q;
    logic [CW-1:0]        count_q;
    logic [PC_WIDTH-1:0]  buf_pc_q  [BUF_DEPTH];
    logic [INS_WIDTH-1:0] buf_ins_q [BUF_DEPTH];

    logic                 pop;
    logic                 push;
    logic                 issue;
    logic                 zero_word;
    logic [CW-1:0]        occupancy;
    logic [IW-1:0]        wr_idx;
    logic [PC_WIDTH-1:0]  pc_next_seq;
    logic [PC_WIDTH-1:0]  redirect_tgt;

    // Handshake: an entry transfers at a rising edge where if_valid and
    // if_ready are both high; if_valid never depends on if_ready.
    assign if_valid = (count_q != '0);
    assign if_ins   = buf_ins_q[0];
    assign if_pc    = buf_pc_q[0];
    assign imem_pc  = pc_q;
    assign halted   = (state_q == ST_HALT);

    always_comb begin
        pop       = if_valid & if_ready;
        occupancy = count_q + CW'(inflight_q);
`ifdef FETCH_HALT_ON_ZERO_EN
        zero_word = inflight_q & ~redirect_valid & (imem_ins == '0);
`else
        zero_word = 1'b0;
`endif
        push  = inflight_q & ~redirect_valid & ~zero_word;
        // Credit counts the in-flight read so the buffer can never overflow.
        issue = ~halted & ~redirect_valid & ~zero_word
              & ((occupancy < CW'(BUF_DEPTH)) | pop);
        wr_idx       = IW'(count_q - CW'(pop));
        pc_next_seq  = (pc_q == PC_WIDTH'(IMEM_DEPTH - 1)) ? '0 : pc_q + 1'b1;
        redirect_tgt = (redirect_pc < PC_WIDTH'(IMEM_DEPTH)) ? redirect_pc : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FETCH;
            pc_q          <= PC_WIDTH'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_pc_q[i]  <= '0;
                buf_ins_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            state_q    <= ST_FETCH;
            pc_q       <= redirect_tgt;
            inflight_q <= 1'b0;
            count_q    <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_next_seq;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
            // Head is always entry 0: shift on pop, then the push lands behind.
            if (pop) begin
                for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                    buf_pc_q[i]  <= buf_pc_q[i+1];
                    buf_ins_q[i] <= buf_ins_q[i+1];
                end
            end
            if (push) begin
                buf_pc_q[wr_idx]  <= inflight_pc_q;
                buf_ins_q[wr_idx] <= imem_ins;
            end
            if (zero_word || state_q == ST_HALT)
                state_q <= ST_HALT;
            else if (issue)
                state_q <= ST_FETCH;
            else
                state_q <= ST_WAIT;
        end
    end

endmodule
